// File: rtl/mask_index_iter_pkg.sv
// mask_index_iter_pkg: shared types and sizing for the mask drainer.
// Holds the drain state enum and the index-width derivation.
package mask_index_iter_pkg;

   typedef enum logic {
      IDLE,
      DRAIN
   } state_t;

   // Index width for an n-bit mask; callers size buses with this.
   function automatic int id_len(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mask_index_iter_if.sv
// mask_index_iter_if: mask-in and index-out handshakes plus clear/count.
// slave = drainer side, master = producer/consumer side.
interface mask_index_iter_if #(
   parameter int N = 32
);
   import mask_index_iter_pkg::*;

   localparam int ID_LEN = id_len(N);

   logic              IN_clear;
   logic              IN_valid;
   logic [N-1:0]      IN_mask;
   logic              OUT_ready;
   logic              OUT_idxValid;
   logic [ID_LEN-1:0] OUT_idx;
   logic              OUT_last;
   logic              IN_idxReady;
   logic [ID_LEN:0]   OUT_remaining;

   modport slave (
      input  IN_clear,
      input  IN_valid,
      input  IN_mask,
      input  IN_idxReady,
      output OUT_ready,
      output OUT_idxValid,
      output OUT_idx,
      output OUT_last,
      output OUT_remaining
   );

   modport master (
      output IN_clear,
      output IN_valid,
      output IN_mask,
      output IN_idxReady,
      input  OUT_ready,
      input  OUT_idxValid,
      input  OUT_idx,
      input  OUT_last,
      input  OUT_remaining
   );

endinterface

// File: rtl/mask_index_iter_penc.sv
// mask_index_iter_penc: combinational lowest-set-bit priority encoder.
// Ports: in (N), idx (lowest set position, 0 if none), any (in != 0).
module mask_index_iter_penc
   import mask_index_iter_pkg::*;
#(
   parameter int N = 32,
   parameter int ID_LEN = id_len(N)
) (
   input  logic [N-1:0]      in,
   output logic [ID_LEN-1:0] idx,
   output logic              any
);

   // Scan high to low so the lowest set bit is written last.
   always_comb begin
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (in[i]) idx = ID_LEN'(i);
      end
   end

   assign any = |in;

endmodule

// File: rtl/mask_index_iter.sv
// mask_index_iter: takes an N-bit mask, emits set-bit indices lowest first.
// Ports: clk, rst (sync, active high), bus (slave: mask in, index out).
module mask_index_iter
   import mask_index_iter_pkg::*;
#(
   parameter int N = 32
) (
   input  logic              clk,
   input  logic              rst,
   mask_index_iter_if.slave  bus
);

   localparam int ID_LEN = id_len(N);
   localparam int CW = ID_LEN + 1;

   state_t            state, state_n;
   logic [N-1:0]      pend, pend_n;
   logic [CW-1:0]     rem, rem_n;
   logic [CW-1:0]     cnt;
   logic [ID_LEN-1:0] low_idx;
   logic              low_any;
   logic              draining;
   logic              last;
   logic              emit;
   logic              accept;

   mask_index_iter_penc #(
      .N      (N),
      .ID_LEN (ID_LEN)
   ) u_penc (
      .in  (pend),
      .idx (low_idx),
      .any (low_any)
   );

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + CW'(bus.IN_mask[i]);
      end
   end

   assign draining = (state == DRAIN) && low_any;
   assign last     = draining && (rem == CW'(1));
   assign emit     = draining && bus.IN_idxReady;

   // Reload is allowed while the final index is being consumed.
   assign bus.OUT_ready = !rst && !bus.IN_clear &&
                          ((state == IDLE) || (last && bus.IN_idxReady));
   assign accept = bus.OUT_ready && bus.IN_valid;

   assign bus.OUT_idxValid  = draining;
   assign bus.OUT_idx       = draining ? low_idx : '0;
   assign bus.OUT_last      = last;
   assign bus.OUT_remaining = rem;

   always_comb begin
      state_n = state;
      pend_n  = pend;
      rem_n   = rem;
      if (emit) begin
         pend_n = pend & (pend - N'(1));
         rem_n  = rem - CW'(1);
         if (last) state_n = IDLE;
      end
      // A zero mask completes the handshake but loads nothing.
      if (accept && (|bus.IN_mask)) begin
         pend_n  = bus.IN_mask;
         rem_n   = cnt;
         state_n = DRAIN;
      end
      if (bus.IN_clear) begin
         state_n = IDLE;
         pend_n  = '0;
         rem_n   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         pend  <= '0;
         rem   <= '0;
      end else begin
         state <= state_n;
         pend  <= pend_n;
         rem   <= rem_n;
      end
   end

endmodule

// File: tb/tb_mask_index_iter.sv
// tb_mask_index_iter: scenario tasks plus a scoreboard of expected indices.
// Expected {idx,last} pairs are queued at accept and popped on handshake.
module tb_mask_index_iter;

   localparam int N = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checks = 0;
   int errors = 0;

   logic [5:0] sb[$];

   always #5 clk = ~clk;

   mask_index_iter_if #(.N(N)) bus ();

   mask_index_iter #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Scoreboard: every index handshake must match the next queued entry.
   always @(negedge clk) begin
      logic [5:0] exp;
      logic [5:0] got;
      if (!rst && bus.OUT_idxValid && bus.IN_idxReady) begin
         checks++;
         got = {bus.OUT_idx, bus.OUT_last};
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected got idx=%0d last=%0d",
                     bus.OUT_idx, bus.OUT_last);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL sb_idx got idx=%0d last=%0d exp idx=%0d last=%0d",
                        got[5:1], got[0], exp[5:1], exp[0]);
            end
         end
      end
   end

   task automatic push_mask(input logic [N-1:0] m);
      int n;
      int k;
      n = $countones(m);
      k = 0;
      for (int i = 0; i < N; i++) begin
         if (m[i]) begin
            k++;
            sb.push_back({5'(i), (k == n)});
         end
      end
   endtask

   // Offer m while idle; returns at #1 after the accept edge.
   task automatic offer(input logic [N-1:0] m);
      @(posedge clk); #1;
      bus.IN_valid = 1'b1;
      bus.IN_mask  = m;
      @(negedge clk);
      checks++;
      if (bus.OUT_ready !== 1'b1) begin
         errors++;
         $display("FAIL offer_ready got=%0b exp=1", bus.OUT_ready);
      end
      @(posedge clk); #1;
      bus.IN_valid = 1'b0;
      bus.IN_mask  = '0;
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      checks++;
      if (bus.OUT_idxValid !== 1'b0 || bus.OUT_remaining !== 6'd0 ||
          bus.OUT_idx !== 5'd0 || bus.OUT_last !== 1'b0) begin
         errors++;
         $display("FAIL %s got v=%0b rem=%0d idx=%0d last=%0b exp 0 0 0 0",
                  tag, bus.OUT_idxValid, bus.OUT_remaining,
                  bus.OUT_idx, bus.OUT_last);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.OUT_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_ready got=%0b exp=0", bus.OUT_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      check_idle("rst_outputs");
      checks++;
      if (bus.OUT_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_ready_after got=%0b exp=1", bus.OUT_ready);
      end
   endtask

   task automatic test_basic();
      logic [5:0] exp_rem;
      push_mask(32'h0000_8421);
      offer(32'h0000_8421);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         exp_rem = 6'(4 - k);
         checks++;
         if (bus.OUT_remaining !== exp_rem || bus.OUT_idxValid !== 1'b1) begin
            errors++;
            $display("FAIL basic_rem got=%0d v=%0b exp=%0d v=1",
                     bus.OUT_remaining, bus.OUT_idxValid, exp_rem);
         end
         if (k == 3) begin
            checks++;
            if (bus.OUT_ready !== 1'b1) begin
               errors++;
               $display("FAIL basic_ready_last got=%0b exp=1", bus.OUT_ready);
            end
         end
      end
      check_idle("basic_done");
   endtask

   task automatic test_zero_full();
      offer('0);
      @(negedge clk);
      checks++;
      if (bus.OUT_idxValid !== 1'b0 || bus.OUT_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_mask got v=%0b rdy=%0b exp v=0 rdy=1",
                  bus.OUT_idxValid, bus.OUT_ready);
      end
      push_mask(32'hFFFF_FFFF);
      offer(32'hFFFF_FFFF);
      @(negedge clk);
      checks++;
      if (bus.OUT_remaining !== 6'd32) begin
         errors++;
         $display("FAIL full_rem got=%0d exp=32", bus.OUT_remaining);
      end
      repeat (31) @(negedge clk);
      check_idle("full_done");
   endtask

   task automatic test_backpressure();
      bus.IN_idxReady = 1'b0;
      push_mask(32'h8000_0001);
      offer(32'h8000_0001);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus.OUT_idxValid !== 1'b1 || bus.OUT_idx !== 5'd0 ||
             bus.OUT_last !== 1'b0 || bus.OUT_remaining !== 6'd2) begin
            errors++;
            $display("FAIL bp_hold got v=%0b idx=%0d last=%0b rem=%0d exp 1 0 0 2",
                     bus.OUT_idxValid, bus.OUT_idx, bus.OUT_last,
                     bus.OUT_remaining);
         end
         @(posedge clk); #1;
      end
      bus.IN_idxReady = 1'b1;
      repeat (2) @(negedge clk);
      check_idle("bp_done");
   endtask

   task automatic test_back_to_back();
      push_mask(32'h0000_0010);
      push_mask(32'h0000_0006);
      offer(32'h0000_0010);
      bus.IN_valid = 1'b1;
      bus.IN_mask  = 32'h0000_0006;
      @(negedge clk);
      checks++;
      if (bus.OUT_ready !== 1'b1 || bus.OUT_idx !== 5'd4) begin
         errors++;
         $display("FAIL b2b_reload got rdy=%0b idx=%0d exp rdy=1 idx=4",
                  bus.OUT_ready, bus.OUT_idx);
      end
      @(posedge clk); #1;
      bus.IN_valid = 1'b0;
      bus.IN_mask  = '0;
      @(negedge clk);
      checks++;
      if (bus.OUT_idxValid !== 1'b1 || bus.OUT_idx !== 5'd1) begin
         errors++;
         $display("FAIL b2b_bubble got v=%0b idx=%0d exp v=1 idx=1",
                  bus.OUT_idxValid, bus.OUT_idx);
      end
      @(negedge clk);
      check_idle("b2b_done");
   endtask

   task automatic test_clear();
      push_mask(32'h0000_00F0);
      offer(32'h0000_00F0);
      @(posedge clk); #1;
      bus.IN_clear = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.OUT_idx !== 5'd5 || bus.OUT_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_cycle got idx=%0d rdy=%0b exp idx=5 rdy=0",
                  bus.OUT_idx, bus.OUT_ready);
      end
      @(posedge clk); #1;
      bus.IN_clear = 1'b0;
      check_idle("clr_idle");
      checks++;
      if (sb.size() != 2) begin
         errors++;
         $display("FAIL clr_consumed got left=%0d exp=2", sb.size());
      end
      sb.delete();
      @(posedge clk); #1;
      bus.IN_clear = 1'b1;
      bus.IN_valid = 1'b1;
      bus.IN_mask  = 32'h0000_0003;
      @(negedge clk);
      checks++;
      if (bus.OUT_ready !== 1'b0) begin
         errors++;
         $display("FAIL clr_valid_ready got=%0b exp=0", bus.OUT_ready);
      end
      @(posedge clk); #1;
      bus.IN_clear = 1'b0;
      bus.IN_valid = 1'b0;
      bus.IN_mask  = '0;
      check_idle("clr_no_accept");
   endtask

   task automatic test_reset_mid();
      push_mask(32'h0000_0F00);
      offer(32'h0000_0F00);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.OUT_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_ready got=%0b exp=0", bus.OUT_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      check_idle("rstmid_outputs");
      checks++;
      if (bus.OUT_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_ready_after got=%0b exp=1", bus.OUT_ready);
      end
      sb.delete();
   endtask

   initial begin
      bus.IN_clear    = 1'b0;
      bus.IN_valid    = 1'b0;
      bus.IN_mask     = '0;
      bus.IN_idxReady = 1'b1;
      test_reset();
      test_basic();
      test_zero_full();
      test_backpressure();
      test_back_to_back();
      test_clear();
      test_reset_mid();
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover got=%0d exp=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
